// File: rtl/rggen_register_access_initiator.sv
// rggen_register_access_initiator
//
// Host-side initiator for the register block's internal access bus. One host
// command is taken at a time over a valid/ready request channel, its byte
// strobe is expanded into a per-bit write mask, and the access is driven onto
// the register bus until the responder completes it or an optional timeout
// expires. The resulting status and read data are returned over a valid/ready
// response channel.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   i_req_*         host command channel (valid/ready, write, address, data, strobe)
//   o_req_ready     command accepted when i_req_valid & o_req_ready
//   o_reg_*         register access strobes (valid, write, address, data, mask)
//   i_reg_ready     responder completes the access, with i_reg_status/i_reg_data
//   o_rsp_*         response channel (valid, status, data), i_rsp_ready from host
//
// Status encoding: 00 OKAY, 01 EXOKAY, 10 SLAVE_ERROR, 11 DECODE_ERROR.
module rggen_register_access_initiator #(
    parameter int ADDRESS_WIDTH  = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int COUNTER_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic                      i_req_write,
    input  logic [ADDRESS_WIDTH-1:0]  i_req_address,
    input  logic [DATA_WIDTH-1:0]     i_req_data,
    input  logic [DATA_WIDTH/8-1:0]   i_req_strobe,
    output logic                      o_reg_valid,
    output logic                      o_reg_write,
    output logic [ADDRESS_WIDTH-1:0]  o_reg_address,
    output logic [DATA_WIDTH-1:0]     o_reg_data,
    output logic [DATA_WIDTH-1:0]     o_reg_mask,
    input  logic                      i_reg_ready,
    input  logic [1:0]                i_reg_status,
    input  logic [DATA_WIDTH-1:0]     i_reg_data,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [1:0]                o_rsp_status,
    output logic [DATA_WIDTH-1:0]     o_rsp_data
);

    localparam int STROBE_WIDTH = DATA_WIDTH / 8;

    // Counter value seen in the last ACCESS cycle before the timeout fires.
    localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_LAST =
        (TIMEOUT_CYCLES > 0) ? COUNTER_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [1:0] STATUS_SLAVE_ERROR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPOND
    } state_e;

    state_e                   state;
    logic [COUNTER_WIDTH-1:0] timeout_count;
    logic                     timeout_hit;

    // Each strobe bit covers one byte lane of the mask.
    function automatic logic [DATA_WIDTH-1:0] expand_strobe(
        input logic [STROBE_WIDTH-1:0] strobe
    );
        logic [DATA_WIDTH-1:0] mask;
        mask = '0;
        for (int i = 0; i < STROBE_WIDTH; i++) begin
            mask[8*i+:8] = {8{strobe[i]}};
        end
        return mask;
    endfunction

    // A zero TIMEOUT_CYCLES disables the abort entirely.
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (timeout_count == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            o_req_ready   <= 1'b0;
            o_reg_valid   <= 1'b0;
            o_reg_write   <= 1'b0;
            o_reg_address <= '0;
            o_reg_data    <= '0;
            o_reg_mask    <= '0;
            o_rsp_valid   <= 1'b0;
            o_rsp_status  <= 2'b00;
            o_rsp_data    <= '0;
            timeout_count <= '0;
        end else begin
            case (state)
                // Ready is registered, so the first IDLE cycle after reset
                // does not accept; later IDLE cycles are entered with it set.
                IDLE: begin
                    o_req_ready <= 1'b1;
                    if (i_req_valid && o_req_ready) begin
                        o_req_ready   <= 1'b0;
                        o_reg_valid   <= 1'b1;
                        o_reg_write   <= i_req_write;
                        o_reg_address <= i_req_address;
                        // Reads carry no data and touch every bit.
                        o_reg_data    <= i_req_write ? i_req_data : '0;
                        o_reg_mask    <= i_req_write ? expand_strobe(i_req_strobe) : '1;
                        timeout_count <= '0;
                        state         <= ACCESS;
                    end
                end

                // Responder ready takes priority over a coincident timeout.
                ACCESS: begin
                    if (i_reg_ready) begin
                        o_reg_valid  <= 1'b0;
                        o_rsp_valid  <= 1'b1;
                        o_rsp_status <= i_reg_status;
                        o_rsp_data   <= o_reg_write ? '0 : i_reg_data;
                        state        <= RESPOND;
                    end else if (timeout_hit) begin
                        o_reg_valid  <= 1'b0;
                        o_rsp_valid  <= 1'b1;
                        o_rsp_status <= STATUS_SLAVE_ERROR;
                        o_rsp_data   <= '0;
                        state        <= RESPOND;
                    end else if (timeout_count != '1) begin
                        timeout_count <= timeout_count + COUNTER_WIDTH'(1);
                    end
                end

                // Response held stable until the host takes it; response
                // registers then keep their values through IDLE.
                RESPOND: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_req_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rggen_register_access_initiator.sv
module tb_rggen_register_access_initiator;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_write;
    logic [7:0]  i_req_address;
    logic [31:0] i_req_data;
    logic [3:0]  i_req_strobe;
    logic        o_reg_valid;
    logic        o_reg_write;
    logic [7:0]  o_reg_address;
    logic [31:0] o_reg_data;
    logic [31:0] o_reg_mask;
    logic        i_reg_ready;
    logic [1:0]  i_reg_status;
    logic [31:0] i_reg_data;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [1:0]  o_rsp_status;
    logic [31:0] o_rsp_data;

    int n_cmp = 0;
    int n_bad = 0;

    rggen_register_access_initiator #(
        .ADDRESS_WIDTH  (8),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TO),
        .COUNTER_WIDTH  (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_write   (i_req_write),
        .i_req_address (i_req_address),
        .i_req_data    (i_req_data),
        .i_req_strobe  (i_req_strobe),
        .o_reg_valid   (o_reg_valid),
        .o_reg_write   (o_reg_write),
        .o_reg_address (o_reg_address),
        .o_reg_data    (o_reg_data),
        .o_reg_mask    (o_reg_mask),
        .i_reg_ready   (i_reg_ready),
        .i_reg_status  (i_reg_status),
        .i_reg_data    (i_reg_data),
        .o_rsp_valid   (o_rsp_valid),
        .i_rsp_ready   (i_rsp_ready),
        .o_rsp_status  (o_rsp_status),
        .o_rsp_data    (o_rsp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: each set strobe bit enables one full byte lane.
    function automatic logic [31:0] strobe_to_mask(input logic [3:0] s);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++)
            if (s[i]) m = m | (32'hFF << (8 * i));
        return m;
    endfunction

    // One complete transaction. d = ACCESS cycle index (0-based) in which the
    // responder raises ready; bp = response backpressure cycles.
    task automatic do_txn(input logic w, input logic [7:0] a, input logic [31:0] wd,
                          input logic [3:0] s, input int d, input logic [1:0] st,
                          input logic [31:0] rd, input int bp);
        logic [31:0] exp_mask, exp_wdata, exp_rdata;
        logic [1:0]  exp_st;
        int          exp_len, cyc, waitc;
        bit          done_ok;
        exp_mask  = w ? strobe_to_mask(s) : 32'hFFFF_FFFF;
        exp_wdata = w ? wd : 32'h0;
        exp_len   = (d < TO) ? d + 1 : TO;
        exp_st    = (d < TO) ? st : 2'b10;
        exp_rdata = (d < TO && !w) ? rd : 32'h0;

        @(posedge clk); #1;
        i_req_valid = 1'b1; i_req_write = w; i_req_address = a;
        i_req_data = wd; i_req_strobe = s;
        waitc = 0;
        @(negedge clk);
        while (!o_req_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (!o_req_ready) begin
            chk("req_accept_bound", 64'(o_req_ready), 64'(1));
            i_req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        // Scramble the request bus; the register bus must not follow it.
        i_req_valid = 1'b0; i_req_write = ~w; i_req_address = 8'($urandom);
        i_req_data = $urandom; i_req_strobe = 4'($urandom);

        done_ok = 1'b0;
        for (cyc = 0; cyc < 40; cyc++) begin
            i_reg_ready  = (cyc == d);
            i_reg_status = (cyc == d) ? st : 2'($urandom);
            i_reg_data   = (cyc == d) ? rd : $urandom;
            @(negedge clk);
            if (!o_reg_valid) begin
                done_ok = 1'b1;
                break;
            end
            chk("reg_write", 64'(o_reg_write), 64'(w));
            chk("reg_address", 64'(o_reg_address), 64'(a));
            chk("reg_data", 64'(o_reg_data), 64'(exp_wdata));
            chk("reg_mask", 64'(o_reg_mask), 64'(exp_mask));
            chk("req_ready_busy", 64'(o_req_ready), 64'(0));
            chk("rsp_valid_busy", 64'(o_rsp_valid), 64'(0));
            @(posedge clk); #1;
        end
        i_reg_ready = 1'b0;
        if (!done_ok) chk("access_end_bound", 64'(o_reg_valid), 64'(0));
        chk("access_len", 64'(cyc), 64'(exp_len));
        chk("rsp_valid", 64'(o_rsp_valid), 64'(1));
        chk("rsp_status", 64'(o_rsp_status), 64'(exp_st));
        chk("rsp_data", 64'(o_rsp_data), 64'(exp_rdata));

        repeat (bp) begin
            @(posedge clk); #1;
            i_req_valid = 1'b1;
            @(negedge clk);
            chk("bp_rsp_valid", 64'(o_rsp_valid), 64'(1));
            chk("bp_rsp_status", 64'(o_rsp_status), 64'(exp_st));
            chk("bp_rsp_data", 64'(o_rsp_data), 64'(exp_rdata));
            chk("bp_req_ready", 64'(o_req_ready), 64'(0));
            chk("bp_reg_valid", 64'(o_reg_valid), 64'(0));
        end
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        i_rsp_ready = 1'b1;
        @(posedge clk); #1;
        i_rsp_ready = 1'b0;
        @(negedge clk);
        chk("post_rsp_valid", 64'(o_rsp_valid), 64'(0));
        chk("post_req_ready", 64'(o_req_ready), 64'(1));
        chk("keep_rsp_status", 64'(o_rsp_status), 64'(exp_st));
        chk("keep_rsp_data", 64'(o_rsp_data), 64'(exp_rdata));
    endtask

    task automatic back_to_back();
        logic [7:0]  addrs [3];
        logic [31:0] datas [3];
        logic [7:0]  seen_a[$];
        logic [31:0] seen_d[$];
        int          seen_c[$];
        int          idx;
        bit          acc;
        addrs = '{8'h30, 8'h34, 8'h38};
        for (int i = 0; i < 3; i++) datas[i] = $urandom;
        idx = 0;
        @(posedge clk); #1;
        i_reg_ready = 1'b1; i_reg_status = 2'b00; i_rsp_ready = 1'b1;
        i_req_valid = 1'b1; i_req_write = 1'b1; i_req_strobe = 4'hF;
        i_req_address = addrs[0]; i_req_data = datas[0];
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (o_reg_valid) begin
                seen_a.push_back(o_reg_address);
                seen_d.push_back(o_reg_data);
                seen_c.push_back(cyc);
            end
            acc = o_req_ready && i_req_valid;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx >= 3) i_req_valid = 1'b0;
                else begin
                    i_req_address = addrs[idx];
                    i_req_data    = datas[idx];
                end
            end
        end
        i_reg_ready = 1'b0; i_rsp_ready = 1'b0;
        chk("b2b_count", 64'(seen_a.size()), 64'(3));
        for (int i = 0; i < seen_a.size() && i < 3; i++) begin
            chk("b2b_addr", 64'(seen_a[i]), 64'(addrs[i]));
            chk("b2b_data", 64'(seen_d[i]), 64'(datas[i]));
            if (i > 0) chk("b2b_spacing", 64'(seen_c[i] - seen_c[i-1]), 64'(3));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; i_req_valid = 1'b0; i_req_write = 1'b0; i_req_address = '0;
        i_req_data = '0; i_req_strobe = '0; i_reg_ready = 1'b0; i_reg_status = '0;
        i_reg_data = '0; i_rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(o_req_ready), 64'(0));
        chk("rst_reg_valid", 64'(o_reg_valid), 64'(0));
        chk("rst_rsp_valid", 64'(o_rsp_valid), 64'(0));
        chk("rst_reg_mask", 64'(o_reg_mask), 64'(0));
        chk("rst_reg_address", 64'(o_reg_address), 64'(0));
        chk("rst_rsp_data", 64'(o_rsp_data), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("first_idle_ready", 64'(o_req_ready), 64'(0));
        @(negedge clk);
        chk("idle_ready", 64'(o_req_ready), 64'(1));

        // Directed cases
        do_txn(1'b1, 8'h10, 32'hA5A5_1234, 4'b0101, 2, 2'b00, 32'h1111_2222, 0);
        do_txn(1'b0, 8'h04, 32'h0, 4'h0, 0, 2'b00, 32'hDEAD_BEEF, 0);
        do_txn(1'b0, 8'h08, 32'h0, 4'hF, 50, 2'b00, 32'h1234_5678, 0);
        do_txn(1'b1, 8'h0C, 32'h0BAD_F00D, 4'hF, TO - 1, 2'b11, 32'h0, 0);
        do_txn(1'b0, 8'h14, 32'h0, 4'h3, 1, 2'b01, 32'hCAFE_0001, 5);
        do_txn(1'b1, 8'h18, 32'hFFFF_FFFF, 4'h0, 1, 2'b00, 32'h0, 1);

        // Reset during ACCESS
        @(posedge clk); #1;
        i_req_valid = 1'b1; i_req_write = 1'b0; i_req_address = 8'h20; i_req_strobe = 4'hF;
        @(negedge clk);
        chk("rstmid_accept_ready", 64'(o_req_ready), 64'(1));
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_in_access", 64'(o_reg_valid), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_reg_valid", 64'(o_reg_valid), 64'(0));
        chk("rstmid_rsp_valid", 64'(o_rsp_valid), 64'(0));
        chk("rstmid_req_ready", 64'(o_req_ready), 64'(0));
        chk("rstmid_reg_address", 64'(o_reg_address), 64'(0));
        chk("rstmid_reg_mask", 64'(o_reg_mask), 64'(0));
        chk("rstmid_rsp_status", 64'(o_rsp_status), 64'(0));
        @(negedge clk);
        chk("rstmid_no_rsp", 64'(o_rsp_valid), 64'(0));
        do_txn(1'b0, 8'h24, 32'h0, 4'h0, 1, 2'b00, 32'h7654_3210, 0);

        back_to_back();

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            do_txn(1'($urandom), 8'($urandom), $urandom, 4'($urandom),
                   int'($urandom_range(0, 6)), 2'($urandom), $urandom,
                   int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
